// File: rtl/lm_pkg.sv
// Shared encodings and helpers for the multi-channel LED manager.
package lm_pkg;

    localparam logic [1:0] LM_MODE_FIXED  = 2'b00;
    localparam logic [1:0] LM_MODE_ROTATE = 2'b01;
    localparam logic [1:0] LM_MODE_PRIO   = 2'b10;

    typedef enum logic {
        LM_IDLE,
        LM_HOLD
    } lm_state_t;

    // Never returns less than 1 so degenerate counts still yield a legal vector.
    function automatic int lm_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/lm_channel_reg.sv
// Sticky capture register for one channel plus its pending flag.
// A capture strobe beats a clear arriving on the same cycle.
module lm_channel_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [WIDTH-1:0] data,
    input  logic             clr,
    output logic [WIDTH-1:0] value,
    output logic             pending
);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            value   <= '0;
            pending <= 1'b0;
        end else if (valid) begin
            value   <= data;
            pending <= 1'b1;
        end else if (clr) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/lm_multi_channel.sv
// LED manager: sticky per-channel capture, one channel multiplexed onto the LEDs
// via fixed select, timed rotation or priority-on-new-event with hold.
module lm_multi_channel
    import lm_pkg::*;
#(
    parameter int                 NUM_CH       = 4,
    parameter int                 WIDTH_CH     = 8,
    parameter int                 WIDTH_LEDS   = 16,
    parameter int                 HOLD_CYCLES  = 50_000_000,
    parameter int                 BLINK_CYCLES = 12_500_000,
    parameter logic [NUM_CH-1:0]  ERR_MASK     = 4'b0110,
    localparam int                IDX_W        = lm_clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH*WIDTH_CH-1:0]   ch_data,
    input  logic [NUM_CH-1:0]            ch_valid,
    input  logic [1:0]                   mode,
    input  logic [IDX_W-1:0]             sel,
    input  logic                         clear_all,
    output logic [NUM_CH-1:0]            pending,
    output logic [WIDTH_LEDS-1:0]        leds
);

    localparam int CNT_W = lm_clog2(HOLD_CYCLES);
    localparam int BLK_W = lm_clog2(BLINK_CYCLES + 1);

    logic [WIDTH_CH-1:0] ch_val [NUM_CH];
    logic [NUM_CH-1:0]   ch_clr;

    lm_state_t        state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [IDX_W-1:0] shown, shown_d;
    logic [1:0]       mode_q, mode_eff;
    logic [BLK_W-1:0] blink_cnt;
    logic             blink_phase;
    logic             expire;
    logic             hold_last;
    logic [IDX_W-1:0] sel_eff, lowest, disp;
    logic             blank;
    logic [WIDTH_LEDS-1:0] leds_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_clr[i] = clear_all | (expire & (shown == IDX_W'(i)));

        lm_channel_reg #(.WIDTH(WIDTH_CH)) u_reg (
            .clk     (clk),
            .rst_n   (rst_n),
            .valid   (ch_valid[i]),
            .data    (ch_data[i*WIDTH_CH +: WIDTH_CH]),
            .clr     (ch_clr[i]),
            .value   (ch_val[i]),
            .pending (pending[i])
        );
    end

    assign mode_eff  = (mode == LM_MODE_ROTATE || mode == LM_MODE_PRIO) ? mode : LM_MODE_FIXED;
    assign sel_eff   = (int'(sel) >= NUM_CH) ? '0 : sel;
    assign hold_last = (cnt == CNT_W'(HOLD_CYCLES - 1));

    always_comb begin
        lowest = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending[i]) lowest = IDX_W'(i);
        end
    end

    // A mode change only resets sequencing; the new mode acts from the next cycle.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        shown_d = shown;
        expire  = 1'b0;
        if (mode_eff != mode_q) begin
            state_d = LM_IDLE;
            cnt_d   = '0;
        end else begin
            case (mode_q)
                LM_MODE_ROTATE: begin
                    if (hold_last) begin
                        cnt_d   = '0;
                        expire  = 1'b1;
                        shown_d = (int'(shown) == NUM_CH - 1) ? '0 : shown + 1'b1;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                LM_MODE_PRIO: begin
                    case (state)
                        LM_IDLE: begin
                            if (|pending) begin
                                shown_d = lowest;
                                cnt_d   = '0;
                                state_d = LM_HOLD;
                            end
                        end
                        LM_HOLD: begin
                            if (hold_last) begin
                                expire  = 1'b1;
                                cnt_d   = '0;
                                state_d = LM_IDLE;
                            end else begin
                                cnt_d = cnt + 1'b1;
                            end
                        end
                        default: state_d = LM_IDLE;
                    endcase
                end
                default: shown_d = sel_eff;
            endcase
        end
    end

    assign disp  = (mode_eff == LM_MODE_FIXED) ? sel_eff : shown;
    assign blank = ERR_MASK[disp] & pending[disp] & ~blink_phase;

    always_comb begin
        leds_d                          = '0;
        leds_d[WIDTH_LEDS-1]            = |pending;
        leds_d[WIDTH_LEDS-2 -: IDX_W]   = disp;
        leds_d[WIDTH_CH-1:0]            = blank ? '0 : ch_val[disp];
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state       <= LM_IDLE;
            cnt         <= '0;
            shown       <= '0;
            mode_q      <= LM_MODE_FIXED;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
            leds        <= '0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            shown  <= shown_d;
            mode_q <= mode_eff;
            leds   <= leds_d;
            if (blink_cnt == BLK_W'(BLINK_CYCLES - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lm_multi_channel.sv
// Directed scenarios plus a random tail, every cycle compared against a dwell/age reference model.
module tb_lm_multi_channel;

    localparam int HOLD  = 8;
    localparam int BLINK = 2;
    localparam logic [3:0] ERR = 4'b0110;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ch_data;
    logic [3:0]  ch_valid;
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic        clear_all;
    logic [3:0]  pending;
    logic [15:0] leds;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          mreg [4];
    logic [3:0]  mpend;
    int          mshown;
    int          hold_left;   // cycles of dwell still to go; 0 means idle
    int          rot_age;     // cycles spent on the current rotate slot
    int          mmode;
    int          ticks;       // clock edges since reset
    logic [15:0] mleds;

    always #5 clk = ~clk;

    lm_multi_channel #(
        .NUM_CH(4), .WIDTH_CH(8), .WIDTH_LEDS(16),
        .HOLD_CYCLES(HOLD), .BLINK_CYCLES(BLINK), .ERR_MASK(ERR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ch_data(ch_data), .ch_valid(ch_valid),
        .mode(mode), .sel(sel), .clear_all(clear_all),
        .pending(pending), .leds(leds)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic model_step();
        int eff, disp, d, lo, old;
        bit expd, phase;
        if (rst_n) begin
            for (int i = 0; i < 4; i++) mreg[i] = 0;
            mpend = '0; mshown = 0; hold_left = 0; rot_age = 0;
            mmode = 0; ticks = 0; mleds = '0;
            return;
        end
        eff   = (mode == 2'd3) ? 0 : int'(mode);
        disp  = (eff == 0) ? int'(sel) : mshown;
        phase = ((ticks / BLINK) % 2) == 0;
        d     = mreg[disp];
        if (ERR[disp] && mpend[disp] && !phase) d = 0;
        mleds        = '0;
        mleds[15]    = |mpend;
        mleds[14:13] = disp[1:0];
        mleds[7:0]   = d[7:0];

        expd = 0;
        old  = mshown;
        if (eff != mmode) begin
            hold_left = 0; rot_age = 0; mmode = eff;
        end else if (eff == 1) begin
            rot_age++;
            if (rot_age == HOLD) begin
                rot_age = 0; expd = 1; mshown = (mshown + 1) % 4;
            end
        end else if (eff == 2) begin
            if (hold_left == 0) begin
                if (|mpend) begin
                    lo = 0;
                    for (int i = 3; i >= 0; i--) if (mpend[i]) lo = i;
                    mshown = lo; hold_left = HOLD;
                end
            end else begin
                hold_left--;
                if (hold_left == 0) expd = 1;
            end
        end else begin
            mshown = int'(sel);
        end
        for (int i = 0; i < 4; i++) begin
            if (ch_valid[i]) begin
                mpend[i] = 1'b1; mreg[i] = int'(ch_data[i*8 +: 8]);
            end else if (clear_all || (expd && old == i)) begin
                mpend[i] = 1'b0;
            end
        end
        ticks++;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("leds", leds, mleds);
        check("pending", {12'b0, pending}, {12'b0, mpend});
    endtask

    initial begin
        int n;
        // 1. reset with random inputs
        rst_n = 1'b1; ch_data = $urandom; ch_valid = 4'($urandom); mode = 2'($urandom);
        sel = 2'($urandom); clear_all = 1'($urandom);
        repeat (3) cycle();
        check("rst_leds", leds, 16'h0000);
        check("rst_pending", {12'b0, pending}, 16'h0000);
        rst_n = 1'b0; mode = 2'd0; sel = 2'd0; ch_valid = '0; clear_all = 1'b0;
        repeat (2) cycle();
        check("idle_leds", leds, 16'h0000);

        // 2. fixed capture on ch3
        ch_data = 32'hA500_0000; ch_valid = 4'b1000; sel = 2'd3;
        cycle();
        ch_valid = '0;
        cycle();
        check("fixed_a5", leds, 16'hE0A5);
        check("fixed_pend3", {15'b0, pending[3]}, 16'h0001);
        cycle();
        check("fixed_still_pend", {15'b0, pending[3]}, 16'h0001);
        clear_all = 1'b1;
        cycle();
        clear_all = 1'b0;
        check("clr_pend", {12'b0, pending}, 16'h0000);
        cycle();
        check("clr_msb", {15'b0, leds[15]}, 16'h0000);

        // 3. priority, two simultaneous events
        mode = 2'd2;
        cycle();
        ch_data = 32'h0011_2200; ch_valid = 4'b0110;
        cycle();
        ch_valid = '0;
        cycle();
        cycle();
        check("prio_first_idx", {14'b0, leds[14:13]}, 16'h0001);
        repeat (22) cycle();
        check("prio_done_pend", {12'b0, pending}, 16'h0000);
        check("prio_done_msb", {15'b0, leds[15]}, 16'h0000);

        // 4. valid colliding with hold expiry
        ch_data = 32'h0000_4400; ch_valid = 4'b0010;
        cycle();
        ch_valid = '0;
        n = 0;
        while (!(hold_left == 1 && mshown == 1) && n < 40) begin cycle(); n++; end
        if (n >= 40) begin
            checks++; errors++;
            $error("FAIL t4_timeout observed=%0d expected=1", hold_left);
        end
        ch_data = 32'h0000_3300; ch_valid = 4'b0010;
        cycle();
        ch_valid = '0;
        check("collide_pend1", {15'b0, pending[1]}, 16'h0001);
        repeat (4) cycle();
        check("collide_reshow", {14'b0, leds[14:13]}, 16'h0001);
        repeat (14) cycle();

        // 5. rotate across all four loaded channels
        n = 0;
        while (pending != 0 && n < 40) begin cycle(); n++; end
        ch_data = $urandom; ch_valid = 4'b1111; mode = 2'd1;
        cycle();
        ch_valid = '0;
        repeat (40) cycle();
        check("rot_cleared", {12'b0, pending}, 16'h0000);

        // 6. reset mid-hold, then a full fresh dwell
        mode = 2'd2;
        cycle();
        ch_data = $urandom; ch_valid = 4'b0001;
        cycle();
        ch_valid = '0;
        n = 0;
        while (hold_left != HOLD - 4 && n < 40) begin cycle(); n++; end
        rst_n = 1'b1;
        cycle();
        check("midrst_leds", leds, 16'h0000);
        check("midrst_pend", {12'b0, pending}, 16'h0000);
        rst_n = 1'b0;
        cycle();
        ch_data = $urandom; ch_valid = 4'b0100;
        n = 0;
        for (int k = 0; k < 16; k++) begin
            cycle();
            ch_valid = '0;
            if (pending[2]) n++;
        end
        check("fresh_dwell", 16'(n), 16'd9);

        // random tail
        for (int k = 0; k < 600; k++) begin
            rst_n     = ($urandom_range(0, 199) == 0);
            ch_valid  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
            ch_data   = $urandom;
            clear_all = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 9) == 0) sel = 2'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
